// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Holds the CSR addresses, cause codes, mstatus bit positions, privilege encodings,
// the sequencer state enum, the CSR write payload and the mstatus update helpers.
package trap_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned PRIV_W = 2;
  localparam int unsigned CODE_W = 4;

  // CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

  // Exception cause codes
  localparam logic [CODE_W-1:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [CODE_W-1:0] EXC_ILLEGAL          = 4'd2;
  localparam logic [CODE_W-1:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [CODE_W-1:0] EXC_ECALL_U          = 4'd8;
  localparam logic [CODE_W-1:0] EXC_ECALL_M          = 4'd11;

  // Interrupt cause codes
  localparam logic [CODE_W-1:0] IRQ_MSI = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI = 4'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI = 4'd11;

  // mie enable bit positions
  localparam int unsigned MIE_MSIE = 3;
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Privilege encodings
  localparam logic [PRIV_W-1:0] PRIV_U = 2'b00;
  localparam logic [PRIV_W-1:0] PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_TVAL   = 3'd3,
    ST_W_STATUS = 3'd4,
    ST_W_MRET   = 3'd5,
    ST_REDIRECT = 3'd6
  } trap_state_e;

  // One CSR write-port transaction
  typedef struct packed {
    logic              we;
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } csr_wr_t;

  function automatic csr_wr_t csr_wr(input logic [CSR_AW-1:0] addr,
                                     input logic [XLEN-1:0]   data);
    csr_wr_t w;
    w.we   = 1'b1;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] mcause_exc(input logic [CODE_W-1:0] code);
    return XLEN'(code);
  endfunction

  function automatic logic [XLEN-1:0] mcause_irq(input logic [CODE_W-1:0] code);
    return {1'b1, (XLEN-1)'(code)};
  endfunction

  // mstatus on trap entry: stash MIE into MPIE, disable, record previous privilege
  function automatic logic [XLEN-1:0] status_on_trap(input logic [XLEN-1:0]   snap,
                                                     input logic [PRIV_W-1:0] priv);
    logic [XLEN-1:0] s;
    s = snap;
    s[MSTATUS_MPIE] = snap[MSTATUS_MIE];
    s[MSTATUS_MIE]  = 1'b0;
    s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv;
    return s;
  endfunction

  // mstatus on mret: restore MIE from MPIE, set MPIE, drop MPP to U
  function automatic logic [XLEN-1:0] status_on_mret(input logic [XLEN-1:0] snap);
    logic [XLEN-1:0] s;
    s = snap;
    s[MSTATUS_MIE]  = snap[MSTATUS_MPIE];
    s[MSTATUS_MPIE] = 1'b1;
    s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    return s;
  endfunction

endpackage

// File: rtl/trap_cause_sel.sv
// Combinational trap priority encoder.
// Inputs: decoded exception events, interrupt lines with their mie enables,
//         mstatus.MIE, current privilege, pc and instr for mtval.
// Outputs: take_c (a trap is selected), is_irq_c, cause_c (full mcause value),
//          tval_c (mtval value). mret is not handled here.
module trap_cause_sel
  import trap_pkg::*;
(
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   instr,
  input  logic              is_instr_misaligned,
  input  logic              is_illegal,
  input  logic              is_ecall,
  input  logic              is_ebreak,
  input  logic              ext_irq,
  input  logic              sw_irq,
  input  logic              tmr_irq,
  input  logic              meie,
  input  logic              msie,
  input  logic              mtie,
  input  logic              mstatus_mie,
  input  logic [PRIV_W-1:0] priv,
  output logic              take_c,
  output logic              is_irq_c,
  output logic [XLEN-1:0]   cause_c,
  output logic [XLEN-1:0]   tval_c
);

  logic irq_en;
  logic mei_pend;
  logic msi_pend;
  logic mti_pend;

  // U-mode always takes enabled interrupts; M-mode needs the global MIE
  assign irq_en   = (priv == PRIV_U) || mstatus_mie;
  assign mei_pend = irq_en && ext_irq && meie;
  assign msi_pend = irq_en && sw_irq  && msie;
  assign mti_pend = irq_en && tmr_irq && mtie;

  // Fixed priority: MEI > MSI > MTI > misaligned > illegal > ebreak > ecall
  always_comb begin
    take_c   = 1'b0;
    is_irq_c = 1'b0;
    cause_c  = '0;
    tval_c   = '0;
    if (mei_pend) begin
      take_c   = 1'b1;
      is_irq_c = 1'b1;
      cause_c  = mcause_irq(IRQ_MEI);
    end else if (msi_pend) begin
      take_c   = 1'b1;
      is_irq_c = 1'b1;
      cause_c  = mcause_irq(IRQ_MSI);
    end else if (mti_pend) begin
      take_c   = 1'b1;
      is_irq_c = 1'b1;
      cause_c  = mcause_irq(IRQ_MTI);
    end else if (is_instr_misaligned) begin
      take_c  = 1'b1;
      cause_c = mcause_exc(EXC_INSTR_MISALIGNED);
      tval_c  = pc;
    end else if (is_illegal) begin
      take_c  = 1'b1;
      cause_c = mcause_exc(EXC_ILLEGAL);
      tval_c  = instr;
    end else if (is_ebreak) begin
      take_c  = 1'b1;
      cause_c = mcause_exc(EXC_BREAKPOINT);
      tval_c  = pc;
    end else if (is_ecall) begin
      take_c  = 1'b1;
      cause_c = mcause_exc((priv == PRIV_U) ? EXC_ECALL_U : EXC_ECALL_M);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer.
// Detects traps and mret in IDLE, then walks the CSR file's single write port
// through mepc/mcause/mtval/mstatus (or mstatus alone for mret), one CSR per
// cycle, while stalling the pipeline; finishes with a one-cycle PC redirect.
// Ports: clk/rst_n; execute-stage instr_valid/pc/instr and decoded events;
//        ext/sw/tmr interrupt lines; live mstatus/mie/mtvec/mepc;
//        CSR write port csr_we/csr_waddr/csr_wdata; trap_stall (combinational);
//        redirect_valid/redirect_pc to fetch; priv_mode (M/U).
module trap_ctrl
  import trap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   instr,
  input  logic              is_instr_misaligned,
  input  logic              is_illegal,
  input  logic              is_ecall,
  input  logic              is_ebreak,
  input  logic              is_mret,
  input  logic              ext_irq,
  input  logic              sw_irq,
  input  logic              tmr_irq,
  input  logic [XLEN-1:0]   mstatus_in,
  input  logic [XLEN-1:0]   mie_in,
  input  logic [XLEN-1:0]   mtvec_in,
  input  logic [XLEN-1:0]   mepc_in,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              trap_stall,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PRIV_W-1:0] priv_mode
);

  trap_state_e       state_q, state_d;
  csr_wr_t           wr_q, wr_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [PRIV_W-1:0] priv_q, priv_d;

  // Values captured at detect; every later write uses these
  logic [XLEN-1:0]   cause_q;
  logic [XLEN-1:0]   epc_q;
  logic [XLEN-1:0]   tval_q;
  logic [XLEN-1:0]   snap_q;
  logic              irq_q;

  logic              sel_take;
  logic              sel_is_irq;
  logic [XLEN-1:0]   sel_cause;
  logic [XLEN-1:0]   sel_tval;

  logic              in_idle;
  logic              trap_go;
  logic              mret_go;
  logic [XLEN-1:0]   trap_base;
  logic [XLEN-1:0]   trap_target;
  logic [XLEN-1:0]   mret_target;
  logic [PRIV_W-1:0] mret_priv;

  logic              unused_csr_bits;
  assign unused_csr_bits = ^{mepc_in[1:0], mie_in[31:12], mie_in[10:8],
                             mie_in[6:4], mie_in[2:0]};

  trap_cause_sel u_cause_sel (
    .pc                  (pc),
    .instr               (instr),
    .is_instr_misaligned (is_instr_misaligned),
    .is_illegal          (is_illegal),
    .is_ecall            (is_ecall),
    .is_ebreak           (is_ebreak),
    .ext_irq             (ext_irq),
    .sw_irq              (sw_irq),
    .tmr_irq             (tmr_irq),
    .meie                (mie_in[MIE_MEIE]),
    .msie                (mie_in[MIE_MSIE]),
    .mtie                (mie_in[MIE_MTIE]),
    .mstatus_mie         (mstatus_in[MSTATUS_MIE]),
    .priv                (priv_q),
    .take_c              (sel_take),
    .is_irq_c            (sel_is_irq),
    .cause_c             (sel_cause),
    .tval_c              (sel_tval)
  );

  // Events only count in IDLE with a valid instruction; a trap suppresses mret
  assign in_idle = (state_q == ST_IDLE);
  assign trap_go = in_idle && instr_valid && sel_take;
  assign mret_go = in_idle && instr_valid && !sel_take && is_mret;

  // Stall covers the detect cycle plus every non-IDLE cycle
  assign trap_stall = trap_go || mret_go || !in_idle;

  // Vectored offset only for interrupts with mtvec mode 01; mode 1x is direct
  assign trap_base   = {mtvec_in[XLEN-1:2], 2'b00};
  assign trap_target = (irq_q && (mtvec_in[1:0] == 2'b01))
                     ? trap_base + XLEN'({cause_q[CODE_W-1:0], 2'b00})
                     : trap_base;
  assign mret_target = {mepc_in[XLEN-1:2], 2'b00};
  assign mret_priv   = (snap_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_M) ? PRIV_M : PRIV_U;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      wr_q             <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      priv_q           <= PRIV_M;
    end else begin
      state_q          <= state_d;
      wr_q             <= wr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      priv_q           <= priv_d;
    end
  end

  // Detect-time capture of cause, epc, tval and the mstatus snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      snap_q  <= '0;
      irq_q   <= 1'b0;
    end else if (trap_go) begin
      cause_q <= sel_cause;
      epc_q   <= pc;
      tval_q  <= sel_tval;
      snap_q  <= mstatus_in;
      irq_q   <= sel_is_irq;
    end else if (mret_go) begin
      snap_q  <= mstatus_in;
      irq_q   <= 1'b0;
    end
  end

  // Next state plus the write/redirect to present in that state
  always_comb begin
    state_d          = state_q;
    wr_d             = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    priv_d           = priv_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_go) begin
          state_d = ST_W_EPC;
          wr_d    = csr_wr(CSR_MEPC, pc);
        end else if (mret_go) begin
          state_d = ST_W_MRET;
          wr_d    = csr_wr(CSR_MSTATUS, status_on_mret(mstatus_in));
        end
      end
      ST_W_EPC: begin
        state_d = ST_W_CAUSE;
        wr_d    = csr_wr(CSR_MCAUSE, cause_q);
      end
      ST_W_CAUSE: begin
        state_d = ST_W_TVAL;
        wr_d    = csr_wr(CSR_MTVAL, tval_q);
      end
      ST_W_TVAL: begin
        state_d = ST_W_STATUS;
        wr_d    = csr_wr(CSR_MSTATUS, status_on_trap(snap_q, priv_q));
      end
      ST_W_STATUS: begin
        state_d          = ST_REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = trap_target;
        priv_d           = PRIV_M;
      end
      ST_W_MRET: begin
        state_d          = ST_REDIRECT;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = mret_target;
        priv_d           = mret_priv;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign csr_we         = wr_q.we;
  assign csr_waddr      = wr_q.addr;
  assign csr_wdata      = wr_q.data;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign priv_mode      = priv_q;

  // epc_q is consumed through the W_EPC write, which is taken straight from pc
  logic unused_epc;
  assign unused_epc = ^epc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: the stimulus side pushes expected CSR writes
// and redirects (with the cycle they must appear in); a monitor pops and
// compares whenever the DUT shows csr_we or redirect_valid.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        is_instr_misaligned, is_illegal, is_ecall, is_ebreak, is_mret;
  logic        ext_irq, sw_irq, tmr_irq;
  logic [31:0] mstatus_in, mie_in, mtvec_in, mepc_in;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        trap_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  priv_mode;

  trap_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instr_valid         (instr_valid),
    .pc                  (pc),
    .instr               (instr),
    .is_instr_misaligned (is_instr_misaligned),
    .is_illegal          (is_illegal),
    .is_ecall            (is_ecall),
    .is_ebreak           (is_ebreak),
    .is_mret             (is_mret),
    .ext_irq             (ext_irq),
    .sw_irq              (sw_irq),
    .tmr_irq             (tmr_irq),
    .mstatus_in          (mstatus_in),
    .mie_in              (mie_in),
    .mtvec_in            (mtvec_in),
    .mepc_in             (mepc_in),
    .csr_we              (csr_we),
    .csr_waddr           (csr_waddr),
    .csr_wdata           (csr_wdata),
    .trap_stall          (trap_stall),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .priv_mode           (priv_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [1:0]  priv;
  } rd_exp_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];
  wr_exp_t mw;
  rd_exp_t mr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] m_priv = 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write / redirect the DUT shows must match the next expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_we) begin
        if (wq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_csr_write: addr 0x%03h data 0x%08h (cycle %0d)",
                   csr_waddr, csr_wdata, cyc);
        end else begin
          mw = wq.pop_front();
          chk("csr_write_cycle", 32'(cyc), 32'(mw.cyc));
          chk("csr_waddr", 32'(csr_waddr), 32'(mw.addr));
          chk("csr_wdata", csr_wdata, mw.data);
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_redirect: pc 0x%08h (cycle %0d)", redirect_pc, cyc);
        end else begin
          mr = rq.pop_front();
          chk("redirect_cycle", 32'(cyc), 32'(mr.cyc));
          chk("redirect_pc", redirect_pc, mr.pc);
          chk("priv_after_redirect", 32'(priv_mode), 32'(mr.priv));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_trap(input int t, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] st, input logic [31:0] tgt);
    wq.push_back('{cyc: t + 1, addr: 12'h341, data: epc});
    wq.push_back('{cyc: t + 2, addr: 12'h342, data: cause});
    wq.push_back('{cyc: t + 3, addr: 12'h343, data: tval});
    wq.push_back('{cyc: t + 4, addr: 12'h300, data: st});
    rq.push_back('{cyc: t + 5, pc: tgt, priv: 2'b11});
    m_priv = 2'b11;
  endtask

  task automatic push_mret(input int t, input logic [31:0] st, input logic [31:0] tgt,
                           input logic [1:0] np);
    wq.push_back('{cyc: t + 1, addr: 12'h300, data: st});
    rq.push_back('{cyc: t + 2, pc: tgt, priv: np});
    m_priv = np;
  endtask

  task automatic quiet();
    instr_valid = 1'b0;
    is_instr_misaligned = 1'b0;
    is_illegal = 1'b0;
    is_ecall = 1'b0;
    is_ebreak = 1'b0;
    is_mret = 1'b0;
    ext_irq = 1'b0;
    sw_irq = 1'b0;
    tmr_irq = 1'b0;
  endtask

  // Garbage on event/interrupt inputs while the sequencer is busy
  task automatic junk();
    instr_valid = 1'($urandom);
    is_instr_misaligned = 1'($urandom);
    is_illegal = 1'($urandom);
    is_ecall = 1'($urandom);
    is_ebreak = 1'($urandom);
    is_mret = 1'($urandom);
    ext_irq = 1'($urandom);
    sw_irq = 1'($urandom);
    tmr_irq = 1'($urandom);
    pc = $urandom;
    instr = $urandom;
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    quiet();
  endtask

  // Checks stall in the detect cycle and through every busy cycle
  task automatic finish_txn(input int busy);
    @(negedge clk);
    chk("stall_detect", 32'(trap_stall), 32'(busy > 0));
    for (int i = 0; i < busy; i++) begin
      @(posedge clk);
      #1;
      junk();
      @(negedge clk);
      chk("stall_busy", 32'(trap_stall), 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csr_we"}, 32'(csr_we), 32'd0);
    chk({tag, "_csr_waddr"}, 32'(csr_waddr), 32'd0);
    chk({tag, "_csr_wdata"}, csr_wdata, 32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_priv"}, 32'(priv_mode), 32'd3);
    chk({tag, "_stall"}, 32'(trap_stall), 32'd0);
  endtask

  // Reference model from the architectural rules; returns busy length
  task automatic model_issue(input int t, output int busy);
    bit          irq_en;
    int          code;
    bit          irq;
    logic [31:0] cause, tval, st, tgt;
    busy = 0;
    if (!instr_valid) return;
    irq_en = (m_priv == 2'b00) || (mstatus_in[3] == 1'b1);
    code = -1;
    irq = 1'b0;
    tval = 32'd0;
    if (irq_en && ext_irq && mie_in[11]) begin code = 11; irq = 1'b1; end
    else if (irq_en && sw_irq && mie_in[3]) begin code = 3; irq = 1'b1; end
    else if (irq_en && tmr_irq && mie_in[7]) begin code = 7; irq = 1'b1; end
    else if (is_instr_misaligned) begin code = 0; tval = pc; end
    else if (is_illegal) begin code = 2; tval = instr; end
    else if (is_ebreak) begin code = 3; tval = pc; end
    else if (is_ecall) code = (m_priv == 2'b00) ? 8 : 11;
    if (code >= 0) begin
      cause = irq ? (32'h8000_0000 | 32'(code)) : 32'(code);
      st = mstatus_in & ~32'h0000_1888;
      if (mstatus_in[3]) st = st | 32'h80;
      if (m_priv == 2'b11) st = st | 32'h1800;
      tgt = mtvec_in & 32'hFFFF_FFFC;
      if (irq && mtvec_in[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
      push_trap(t, pc, cause, tval, st, tgt);
      busy = 5;
    end else if (is_mret) begin
      st = mstatus_in & ~32'h0000_1888;
      if (mstatus_in[7]) st = st | 32'h8;
      st = st | 32'h80;
      push_mret(t, st, mepc_in & 32'hFFFF_FFFC,
                (mstatus_in[12:11] == 2'b11) ? 2'b11 : 2'b00);
      busy = 2;
    end
  endtask

  int busy;
  int t;

  initial begin
    quiet();
    pc = 0; instr = 0; mstatus_in = 0; mie_in = 0; mtvec_in = 0; mepc_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ebreak in M-mode
    start();
    instr_valid = 1; is_ebreak = 1; pc = 32'h100; instr = 32'h0010_0073;
    mtvec_in = 32'h200; mstatus_in = 32'h8; mie_in = 0;
    t = cyc;
    push_trap(t, 32'h100, 32'd3, 32'h100, 32'h1880, 32'h200);
    finish_txn(5);
    start();
    @(negedge clk);
    chk("redirect_pc_hold", redirect_pc, 32'h200);
    chk("redirect_single_cycle", 32'(redirect_valid), 32'd0);

    // mret to U-mode
    start();
    instr_valid = 1; is_mret = 1; mstatus_in = 32'h80; mepc_in = 32'h400;
    t = cyc;
    push_mret(t, 32'h88, 32'h400, 2'b00);
    finish_txn(2);

    // Vectored timer interrupt from U-mode
    start();
    instr_valid = 1; tmr_irq = 1; pc = 32'h40; mtvec_in = 32'h1001;
    mie_in = 32'h80; mstatus_in = 32'h0;
    t = cyc;
    push_trap(t, 32'h40, 32'h8000_0007, 32'h0, 32'h0, 32'h101C);
    finish_txn(5);

    // illegal + ebreak together
    start();
    instr_valid = 1; is_illegal = 1; is_ebreak = 1; instr = 32'hFFFF_FFFF; pc = 32'h80;
    mstatus_in = 32'h8; mtvec_in = 32'h300; mie_in = 0;
    t = cyc;
    push_trap(t, 32'h80, 32'd2, 32'hFFFF_FFFF, 32'h1880, 32'h300);
    finish_txn(5);

    // Same with an enabled external interrupt (and mret, which is dropped)
    start();
    instr_valid = 1; is_illegal = 1; is_ebreak = 1; is_mret = 1; ext_irq = 1;
    instr = 32'hFFFF_FFFF; pc = 32'h80; mstatus_in = 32'h8; mtvec_in = 32'h300;
    mie_in = 32'h800;
    t = cyc;
    push_trap(t, 32'h80, 32'h8000_000B, 32'h0, 32'h1880, 32'h300);
    finish_txn(5);

    // Software interrupt masked in M-mode with MIE=0
    start();
    instr_valid = 1; sw_irq = 1; mie_in = 32'h8; mstatus_in = 32'h0; pc = 32'h44;
    mtvec_in = 32'h200;
    finish_txn(0);

    // Drop to U-mode, then the same interrupt is taken
    start();
    instr_valid = 1; is_mret = 1; mstatus_in = 32'h0; mepc_in = 32'h500;
    t = cyc;
    push_mret(t, 32'h80, 32'h500, 2'b00);
    finish_txn(2);
    start();
    instr_valid = 1; sw_irq = 1; mie_in = 32'h8; mstatus_in = 32'h0; pc = 32'h44;
    mtvec_in = 32'h200;
    t = cyc;
    push_trap(t, 32'h44, 32'h8000_0003, 32'h0, 32'h0, 32'h200);
    finish_txn(5);

    // Reset during W_CAUSE
    start();
    instr_valid = 1; is_ecall = 1; pc = 32'h600; mstatus_in = 32'h8; mtvec_in = 32'h700;
    mie_in = 0;
    t = cyc;
    push_trap(t, 32'h600, 32'd11, 32'h0, 32'h1880, 32'h700);
    @(negedge clk);
    chk("stall_detect", 32'(trap_stall), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      junk();
    end
    @(negedge clk);
    #1;
    quiet();
    rst_n = 1'b0;
    wq.delete();
    rq.delete();
    m_priv = 2'b11;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_reset_we", 32'(csr_we), 32'd0);
    chk("post_reset_priv", 32'(priv_mode), 32'd3);

    // Randomized transactions against the model
    for (int i = 0; i < 300; i++) begin
      start();
      instr_valid = ($urandom_range(0, 9) != 0);
      is_instr_misaligned = ($urandom_range(0, 7) == 0);
      is_illegal = ($urandom_range(0, 6) == 0);
      is_ebreak = ($urandom_range(0, 6) == 0);
      is_ecall = ($urandom_range(0, 5) == 0);
      is_mret = ($urandom_range(0, 2) == 0);
      ext_irq = ($urandom_range(0, 4) == 0);
      sw_irq = ($urandom_range(0, 4) == 0);
      tmr_irq = ($urandom_range(0, 4) == 0);
      pc = $urandom;
      instr = $urandom;
      mstatus_in = $urandom;
      mie_in = $urandom;
      mtvec_in = $urandom;
      mepc_in = $urandom;
      model_issue(cyc, busy);
      finish_txn(busy);
    end

    start();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("writes_outstanding", 32'(wq.size()), 32'd0);
    chk("redirects_outstanding", 32'(rq.size()), 32'd0);
    chk("final_priv", 32'(priv_mode), 32'(m_priv));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
